// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: shared widths, op codes and sequencer states.
package shift_sequencer_pkg;
    localparam int DATA_WIDTH  = 32;
    localparam int SHAMT_WIDTH = 5;
    typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROTL = 2'b11} op_e;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_PASS1 = 2'b01, S_PASS2 = 2'b10, S_RESP = 2'b11} state_e;
endpackage

// File: rtl/shift_sequencer_barrel.sv
// BARREL_SHIFTER32: combinational 32-bit logical shifter, lnr=1 shifts left.
module BARREL_SHIFTER32 (
    input  logic [31:0] in_data,
    input  logic [4:0]  shamt,
    input  logic        lnr,
    output logic [31:0] out_data
);
    assign out_data = lnr ? in_data << shamt : in_data >> shamt;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences one or two passes through a single barrel shifter
// to implement SLL, SRL, SRA and ROTL behind valid/ready handshakes.
module shift_sequencer #(
    parameter int DATA_WIDTH  = shift_sequencer_pkg::DATA_WIDTH,
    parameter int SHAMT_WIDTH = shift_sequencer_pkg::SHAMT_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [DATA_WIDTH-1:0]  req_data,
    input  logic [SHAMT_WIDTH-1:0] req_shamt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_data
);
    import shift_sequencer_pkg::*;

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [DATA_WIDTH-1:0]  d_q, d_d, acc_q, acc_d;
    logic [SHAMT_WIDTH-1:0] s_q, s_d;
    logic [DATA_WIDTH-1:0]  sh_in, sh_out, sh_res;
    logic [SHAMT_WIDTH-1:0] sh_amt;
    logic                   sh_lnr, inv;

    assign req_ready = RST && state_q == S_IDLE;
    assign rsp_valid = RST && state_q == S_RESP;
    assign rsp_data  = acc_q;

    BARREL_SHIFTER32 u_shifter (
        .in_data (sh_in),
        .shamt   (sh_amt),
        .lnr     (sh_lnr),
        .out_data(sh_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        d_d     = d_q;
        s_d     = s_q;
        acc_d   = acc_q;
        // Negative SRA operands are shifted inverted so the zero fill becomes sign fill.
        inv     = state_q == S_PASS1 && op_q == OP_SRA && d_q[DATA_WIDTH-1];
        sh_in   = inv ? ~d_q : d_q;
        sh_amt  = state_q == S_PASS2 ? SHAMT_WIDTH'(0) - s_q : s_q;
        sh_lnr  = state_q == S_PASS1 && (op_q == OP_SLL || op_q == OP_ROTL);
        sh_res  = inv ? ~sh_out : sh_out;
        case (state_q)
            S_IDLE: if (req_valid) begin
                state_d = S_PASS1;
                op_d    = op_e'(req_op);
                d_d     = req_data;
                s_d     = req_shamt;
            end
            S_PASS1: begin
                acc_d   = (op_q == OP_ROTL && s_q == '0) ? d_q : sh_res;
                state_d = (op_q == OP_ROTL && s_q != '0) ? S_PASS2 : S_RESP;
            end
            S_PASS2: begin
                acc_d   = acc_q | sh_res;
                state_d = S_RESP;
            end
            default: state_d = rsp_ready ? S_IDLE : S_RESP;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            d_q     <= d_d;
            s_q     <= s_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed and random checks of shift_sequencer against a
// behavioural shift/rotate model, including backpressure and reset cases.
module tb_shift_sequencer;
    logic        CLK = 0;
    logic        RST;
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0]  req_op;
    logic [31:0] req_data, rsp_data;
    logic [4:0]  req_shamt;
    int          checks = 0;
    int          errors = 0;

    shift_sequencer dut (
        .CLK      (CLK),
        .RST      (RST),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_data (req_data),
        .req_shamt(req_shamt),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
        logic [63:0] w;
        w = {d, d} << s;
        case (op)
            2'd0:    return d << s;
            2'd1:    return d >> s;
            2'd2:    return 32'($signed(d) >>> s);
            default: return w[63:32];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
        chk("req_ready_before_send", 32'(req_ready), 32'd1);
        req_valid = 1;
        req_op    = op;
        req_data  = d;
        req_shamt = s;
        @(posedge CLK); #1;
        req_valid = 0;
    endtask

    task automatic collect(input logic [31:0] exp, input int exp_lat);
        int lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_data", rsp_data, exp);
    endtask

    task automatic complete();
        @(posedge CLK); #1;
        chk("rsp_valid_after_done", 32'(rsp_valid), 32'd0);
        chk("req_ready_after_done", 32'(req_ready), 32'd1);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
        send(op, d, s);
        collect(model(op, d, s), (op == 2'd3 && s != 0) ? 3 : 2);
        complete();
    endtask

    initial begin
        RST = 0; req_valid = 0; rsp_ready = 1;
        req_op = 0; req_data = 0; req_shamt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk("pwrup_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("pwrup_rsp_data", rsp_data, 32'd0);
            chk("pwrup_req_ready", 32'(req_ready), 32'd0);
            req_valid = (i == 0);
        end
        req_valid = 0;
        RST = 1; #1;
        chk("pwrup_ready_after", 32'(req_ready), 32'd1);
        chk("pwrup_no_rsp", 32'(rsp_valid), 32'd0);

        run(2'd0, 32'h00000001, 5'd2);
        run(2'd1, 32'h9078af1b, 5'h14);
        run(2'd2, 32'h9078af1b, 5'h14);
        chk("sra_plan_value", model(2'd2, 32'h9078af1b, 5'h14), 32'hFFFFF907);
        run(2'd3, 32'h7811bf90, 5'd4);
        run(2'd3, 32'h198af7b1, 5'h1f);
        run(2'd3, 32'hffffffff, 5'd0);
        run(2'd2, 32'h80000000, 5'h1f);
        run(2'd3, 32'h80000001, 5'd1);

        // Backpressure with a new request waiting on the bus.
        rsp_ready = 0;
        send(2'd0, 32'h00ff00ff, 5'd8);
        collect(32'hff00ff00, 2);
        req_valid = 1; req_op = 2'd1; req_data = 32'hf0000000; req_shamt = 5'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", rsp_data, 32'hff00ff00);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1;
        @(posedge CLK); #1;
        chk("bp_rsp_done", 32'(rsp_valid), 32'd0);
        chk("bp_ready_rise", 32'(req_ready), 32'd1);
        @(posedge CLK); #1;
        req_valid = 0;
        chk("bp_accepted", 32'(req_ready), 32'd0);
        collect(32'h0f000000, 2);
        complete();

        // Reset during the second rotate pass.
        send(2'd3, 32'h12345678, 5'd4);
        @(posedge CLK); #1;
        RST = 0;
        @(posedge CLK); #1;
        RST = 1; #1;
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            chk("rst_mid_quiet", 32'(rsp_valid), 32'd0);
        end
        run(2'd0, 32'h00000001, 5'd1);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] d;
            logic [4:0]  s;
            op = 2'($urandom_range(0, 3));
            d  = $urandom;
            s  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            run(op, d, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift/rotate unit that sits directly upstream of `BARREL_SHIFTER32` and drives it. It accepts one shift request over a valid/ready handshake and sequences one or two passes through a single shifter instance. This implements logical left, logical right, arithmetic right and rotate-left. The registered result goes back to the ALU result mux over a second valid/ready handshake.

## Interface
- `DATA_WIDTH`, default 32: operand and result width. Fixed at 32 by the shifter.
- `SHAMT_WIDTH`, default 5: shift-amount width.
- `CLK`  in  1: single clock; all state updates on its rising edge.
- `RST`  in  1: synchronous, active-low reset, sampled on the rising edge of `CLK`.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request.
- `req_op`  in  2: 00 SLL, 01 SRL, 10 SRA, 11 ROTL.
- `req_data`  in  32: operand D.
- `req_shamt`  in  5: shift amount S.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer takes the result.
- `rsp_data`  out  32: result.

## Operation
- States:
  - IDLE, PASS1, PASS2, RESP.
  - Registers: `op_q`, `d_q`, `s_q`, `acc_q`.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch op/D/S and go to PASS1.
- PASS1 drives the shifter as follows (LnR: 1=left, 0=right):
  - SLL: D, S, left.
  - SRL: D, S, right.
  - SRA: if D[31]=0 then D, S, right; else ~D, S, right, and invert the shifter output. This gives sign fill.
  - ROTL: D, S, left.
- PASS1 exit:
  - SLL/SRL/SRA: `acc_q` ← pass result, go to RESP.
  - ROTL with S≠0: `acc_q` ← pass result, go to PASS2.
  - ROTL with S=0: `acc_q` ← D, go to RESP. No second pass.
- PASS2 (ROTL only):
  - Drive D, amount (32−S) truncated to 5 bits, right.
  - `acc_q` ← `acc_q` | shifter output.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1 and `rsp_data`=`acc_q`.
  - Stay until `rsp_ready`=1, then go to IDLE.
- Arithmetic: the only arithmetic is the 5-bit wrap of 32−S; S=0 never reaches PASS2.
- Requests arriving outside IDLE are not accepted, since `req_ready`=0. The requester holds them.

## Timing
- Reset (`RST`=0 at a rising edge):
  - Next state is IDLE; `acc_q`=0; `rsp_valid`=0; `rsp_data`=0.
  - `req_ready` is forced 0 in any cycle where `RST`=0.
- Reset mid-operation (PASS1/PASS2/RESP): the operation is discarded, no response is produced, and the unit is in IDLE the cycle after reset deasserts.
- Latency, counting accept edge = T:
  - SLL/SRL/SRA and ROTL with S=0: `rsp_valid` high from T+2.
  - ROTL with S≠0: `rsp_valid` high from T+3.
- Handshake rules:
  - `rsp_valid` and `rsp_data` stay stable while `rsp_ready`=0.
  - The response completes on the edge where `rsp_valid`&&`rsp_ready`.
  - `req_ready` rises the cycle after that edge. There is no same-cycle response-to-request turnaround.
- Maximum throughput: one request per 3 cycles for single-pass ops, one per 4 cycles for ROTL.
- The shifter is purely combinational. Its inputs are driven from registers only, with no combinational path from `req_*` to the shifter.

## Structure
- Op encodings (`OP_SLL`..`OP_ROTL`), state encodings and `DATA_WIDTH` go in the shared project definitions include.
- Sub-module: exactly one `BARREL_SHIFTER32` instance. Its inputs are muxed by state/op, and output inversion for SRA is applied around it.
- Next-state logic and the datapath mux are combinational; state and `acc_q` are registered.

## Test plan
1. SLL, D=0x00000001, S=2 -> `rsp_data`=0x00000004, `rsp_valid` at T+2.
2. SRL then SRA, D=0x9078af1b, S=0x14 -> 0x00000907, then 0xFFFFF907.
3. ROTL, D=0x7811bf90, S=4 -> 0x811bf907 at T+3. ROTL, D=0x198af7b1, S=0x1f -> 0x8CC57BD8. ROTL, D=0xffffffff, S=0 -> 0xffffffff at T+2.
4. Backpressure: hold `rsp_ready`=0 for 5 cycles with `req_valid`=1 and a new request on the bus:
   - `rsp_data` holds steady and `req_ready` stays 0.
   - After `rsp_ready`=1, the new request is accepted exactly one cycle after the response completes.
5. Reset mid-op: ROTL accepted, then `RST`=0 for one edge during PASS2 -> `rsp_valid` never asserts for it. `req_ready`=1 in the first cycle with `RST`=1, and a following SLL D=0x1, S=1 -> 0x2.
6. Power-up: `RST`=0 for 3 cycles -> `rsp_valid`=0, `rsp_data`=0, `req_ready`=0 throughout, and a `req_valid` pulse is ignored.
